// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================
// Module  : alu_pipe_if
// Brief   : Operand/op and result/flag channels of alu_pipe
// Revision: 1.0
// ============================================================
interface alu_pipe_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       unit_sel;
  logic [1:0]       func;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             carry_out;
  logic             over_flow;
  logic             flag_zero;
  logic             A_bigger;
  logic             B_bigger;
  logic             A_equal_B;

  // ALU side
  modport slave (
    input  in_valid, A, B, unit_sel, func, out_ready,
    output in_ready, out_valid, F, carry_out, over_flow, flag_zero,
           A_bigger, B_bigger, A_equal_B
  );

  // Operand source / result sink side
  modport master (
    output in_valid, A, B, unit_sel, func, out_ready,
    input  in_ready, out_valid, F, carry_out, over_flow, flag_zero,
           A_bigger, B_bigger, A_equal_B
  );

endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================
// Module  : alu_pipe
// Brief   : WIDTH-bit ALU, valid/ready handshake, shift-add multiply
// Revision: 1.0
// ============================================================
module alu_pipe #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic      CLK,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int c_log2w = $clog2(WIDTH);
  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);

  localparam logic [1:0] c_unit_arith = 2'b00;
  localparam logic [1:0] c_unit_logic = 2'b01;
  localparam logic [1:0] c_unit_shift = 2'b10;
  localparam logic [1:0] c_unit_mul   = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_mul_hi;
  logic                 r_mul_agt;
  logic                 r_mul_bgt;
  logic                 r_mul_eq;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_f;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_zero;
  logic                 r_agt;
  logic                 r_bgt;
  logic                 r_eq;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_mul_done;

  logic [WIDTH-1:0]     w_op2;
  logic [WIDTH:0]       w_add_ext;
  logic [WIDTH:0]       w_sub_ext;
  logic [c_log2w-1:0]   w_shamt;
  logic [c_log2w-1:0]   w_shamt_m1;
  logic [2*WIDTH-1:0]   w_shl_ext;
  logic signed [WIDTH-1:0] w_a_signed;
  logic                 w_shr_carry;

  logic [WIDTH-1:0]     w_res;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_agt;
  logic                 w_bgt;
  logic                 w_eq;

  logic [WIDTH-1:0]     w_mul_f;
  logic [WIDTH-1:0]     w_mul_hi;

  // ---------------- handshake ----------------
  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.unit_sel == c_unit_mul);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == c_cnt_last);

  // ---------------- single-cycle units ----------------
  // inc/dec reuse the add/sub path with the second operand forced to 1
  assign w_op2       = bus.func[1] ? WIDTH'(1) : bus.B;
  assign w_add_ext   = {1'b0, bus.A} + {1'b0, w_op2};
  assign w_sub_ext   = {1'b0, bus.A} - {1'b0, w_op2};
  assign w_shamt     = bus.B[c_log2w-1:0];
  assign w_shamt_m1  = w_shamt - c_log2w'(1);
  assign w_shl_ext   = {{WIDTH{1'b0}}, bus.A} << w_shamt;
  assign w_a_signed  = bus.A;
  assign w_shr_carry = (w_shamt != '0) && bus.A[w_shamt_m1];

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.unit_sel)
      c_unit_arith: begin
        if (!bus.func[0]) begin
          w_res   = w_add_ext[WIDTH-1:0];
          w_carry = w_add_ext[WIDTH];
          w_ovf   = (bus.A[WIDTH-1] == w_op2[WIDTH-1]) &&
                    (w_res[WIDTH-1] != bus.A[WIDTH-1]);
        end else begin
          w_res   = w_sub_ext[WIDTH-1:0];
          w_carry = w_sub_ext[WIDTH];
          w_ovf   = (bus.A[WIDTH-1] != w_op2[WIDTH-1]) &&
                    (w_res[WIDTH-1] != bus.A[WIDTH-1]);
        end
      end
      c_unit_logic: begin
        case (bus.func)
          2'b00:   w_res = bus.A & bus.B;
          2'b01:   w_res = bus.A | bus.B;
          2'b10:   w_res = bus.A ^ bus.B;
          default: w_res = ~bus.A;
        endcase
      end
      c_unit_shift: begin
        // Shifting into a double-width word leaves the last bit out at index WIDTH
        case (bus.func)
          2'b00: begin
            w_res   = w_shl_ext[WIDTH-1:0];
            w_carry = w_shl_ext[WIDTH];
          end
          2'b01: begin
            w_res   = bus.A >> w_shamt;
            w_carry = w_shr_carry;
          end
          2'b10: begin
            w_res   = w_a_signed >>> w_shamt;
            w_carry = w_shr_carry;
          end
          default: begin
            w_res   = w_shl_ext[WIDTH-1:0] | w_shl_ext[2*WIDTH-1:WIDTH];
            w_carry = w_shl_ext[WIDTH];
          end
        endcase
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // ---------------- compare ----------------
  generate
    if (SIGNED_CMP) begin : g_cmp_signed
      assign w_agt = $signed(bus.A) > $signed(bus.B);
      assign w_bgt = $signed(bus.A) < $signed(bus.B);
    end else begin : g_cmp_unsigned
      assign w_agt = bus.A > bus.B;
      assign w_bgt = bus.A < bus.B;
    end
  endgenerate
  assign w_eq = (bus.A == bus.B);

  assign w_mul_hi = r_prod[2*WIDTH-1:WIDTH];
  assign w_mul_f  = r_mul_hi ? w_mul_hi : r_prod[WIDTH-1:0];

  // ---------------- FSM, multiplier and output register ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_mul_hi    <= 1'b0;
      r_mul_agt   <= 1'b0;
      r_mul_bgt   <= 1'b0;
      r_mul_eq    <= 1'b0;
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_agt       <= 1'b0;
      r_bgt       <= 1'b0;
      r_eq        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state   <= S_MUL;
            r_mcand   <= {{WIDTH{1'b0}}, bus.A};
            r_mplier  <= bus.B;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_mul_hi  <= bus.func[0];
            r_mul_agt <= w_agt;
            r_mul_bgt <= w_bgt;
            r_mul_eq  <= w_eq;
          end
          if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_f         <= w_res;
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_zero      <= (w_res == '0);
            r_agt       <= w_agt;
            r_bgt       <= w_bgt;
            r_eq        <= w_eq;
          end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          // Entry into MUL already required the output register to be free
          if (w_mul_done) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b1;
            r_f         <= w_mul_f;
            r_carry     <= (w_mul_hi != '0);
            r_ovf       <= 1'b0;
            r_zero      <= (w_mul_f == '0);
            r_agt       <= r_mul_agt;
            r_bgt       <= r_mul_bgt;
            r_eq        <= r_mul_eq;
          end else begin
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.F         = r_f;
  assign bus.carry_out = r_carry;
  assign bus.over_flow = r_ovf;
  assign bus.flag_zero = r_zero;
  assign bus.A_bigger  = r_agt;
  assign bus.B_bigger  = r_bgt;
  assign bus.A_equal_B = r_eq;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// Bench for alu_pipe: an unsigned-compare and a signed-compare instance share stimulus;
// expected results are queued at accept and popped by an independent output monitor.
module tb_alu_pipe;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [1:0] unit_in = '0;
  logic [1:0] func_in = '0;
  logic       out_ready = 1'b1;
  bit         rand_bp = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] f;
    logic c, v, z, agu, bgu, eq, ags, bgs;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  alu_pipe_if #(.WIDTH(W)) bus_u ();
  alu_pipe_if #(.WIDTH(W)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.A         = a_in;
  assign bus_u.B         = b_in;
  assign bus_u.unit_sel  = unit_in;
  assign bus_u.func      = func_in;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.A         = a_in;
  assign bus_s.B         = b_in;
  assign bus_s.unit_sel  = unit_in;
  assign bus_s.func      = func_in;
  assign bus_s.out_ready = out_ready;

  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut_u (.CLK(CLK), .rst_n(rst_n), .bus(bus_u.slave));
  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut_s (.CLK(CLK), .rst_n(rst_n), .bus(bus_s.slave));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic [1:0] u, input logic [1:0] fn,
                                 input logic [7:0] a8, input logic [7:0] b8);
    exp_t e;
    int a, b, sa, sbv, bb, sbb, r, sr, n, p;
    a = int'(a8);
    b = int'(b8);
    sa  = (a >= 128) ? a - 256 : a;
    sbv = (b >= 128) ? b - 256 : b;
    e.c = 1'b0;
    e.v = 1'b0;
    r = 0;
    case (u)
      2'd0: begin
        bb  = fn[1] ? 1 : b;
        sbb = fn[1] ? 1 : sbv;
        if (!fn[0]) begin
          r = a + bb; sr = sa + sbb; e.c = (r > 255);
        end else begin
          r = a - bb; sr = sa - sbb; e.c = (a < bb);
        end
        e.v = (sr > 127) || (sr < -128);
      end
      2'd1: begin
        case (fn)
          2'd0: r = a & b;
          2'd1: r = a | b;
          2'd2: r = a ^ b;
          default: r = ~a;
        endcase
      end
      2'd2: begin
        n = b % 8;
        case (fn)
          2'd0: begin r = a << n; e.c = (n > 0) && (((a >> (8 - n)) & 1) == 1); end
          2'd1: begin r = a >> n; e.c = (n > 0) && (((a >> (n - 1)) & 1) == 1); end
          2'd2: begin r = sa >>> n; e.c = (n > 0) && (((a >> (n - 1)) & 1) == 1); end
          default: begin
            r = (a << n) | (a >> (8 - n));
            e.c = (n > 0) && ((r & 1) == 1);
          end
        endcase
      end
      default: begin
        p = a * b;
        r = fn[0] ? (p >> 8) : p;
        e.c = ((p >> 8) != 0);
      end
    endcase
    r = r & 255;
    e.f = r[7:0];
    e.z = (r == 0);
    e.agu = (a > b);
    e.bgu = (a < b);
    e.eq  = (a == b);
    e.ags = (sa > sbv);
    e.bgs = (sa < sbv);
    return e;
  endfunction

  // Drive an op at posedge+1, hold until accepted, queue its expected result
  task automatic issue(input logic [1:0] u, input logic [1:0] fn,
                       input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    unit_in = u; func_in = fn; a_in = a; b_in = b;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge CLK);
      ok = bus_u.in_ready;
      if (ok) sb.push_back(model(u, fn, a, b));
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout: op %0d/%0d never accepted", u, fn);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Output monitor
  always @(negedge CLK) begin
    if (rst_n && bus_u.out_valid) begin
      if (sb.size() == 0) begin
        chk("stale_result_valid", 32'(bus_u.out_valid), 32'd0);
      end else begin
        m_e = sb[0];
        chk("F",         32'(bus_u.F),         32'(m_e.f));
        chk("carry_out", 32'(bus_u.carry_out), 32'(m_e.c));
        chk("over_flow", 32'(bus_u.over_flow), 32'(m_e.v));
        chk("flag_zero", 32'(bus_u.flag_zero), 32'(m_e.z));
        chk("cmp_unsigned", {29'd0, bus_u.A_bigger, bus_u.B_bigger, bus_u.A_equal_B},
            {29'd0, m_e.agu, m_e.bgu, m_e.eq});
        chk("valid_s",   32'(bus_s.out_valid), 32'd1);
        chk("F_s",       32'(bus_s.F),         32'(m_e.f));
        chk("cmp_signed", {29'd0, bus_s.A_bigger, bus_s.B_bigger, bus_s.A_equal_B},
            {29'd0, m_e.ags, m_e.bgs, m_e.eq});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge CLK) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [7:0] pick [5];

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", 32'(bus_u.out_valid), 32'd0);
    chk("rst_F", 32'(bus_u.F), 32'd0);
    chk("rst_flags", {26'd0, bus_u.carry_out, bus_u.over_flow, bus_u.flag_zero,
                      bus_u.A_bigger, bus_u.B_bigger, bus_u.A_equal_B}, 32'd0);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    chk("in_ready_after_rst", 32'(bus_u.in_ready), 32'd1);

    // Directed ops
    issue(2'd0, 2'd0, 8'hFF, 8'h01);
    issue(2'd0, 2'd1, 8'h80, 8'h01);
    issue(2'd0, 2'd2, 8'h7F, 8'h00);
    issue(2'd0, 2'd3, 8'h00, 8'h00);
    issue(2'd1, 2'd2, 8'hA5, 8'hA5);
    issue(2'd1, 2'd3, 8'hFF, 8'h10);
    issue(2'd2, 2'd2, 8'h90, 8'h03);
    issue(2'd2, 2'd3, 8'h81, 8'h01);
    issue(2'd2, 2'd0, 8'h55, 8'h00);
    issue(2'd2, 2'd1, 8'h81, 8'h07);

    // Three back-to-back ADDs
    issue(2'd0, 2'd0, 8'h10, 8'h20);
    issue(2'd0, 2'd0, 8'h30, 8'h40);
    issue(2'd0, 2'd0, 8'hF0, 8'h20);
    @(negedge CLK);
    chk("b2b_third_valid", 32'(bus_u.out_valid), 32'd1);
    @(posedge CLK);
    #1;
    idle(2);

    // Back-pressure: hold result, block new op, then drain+accept on one edge
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 8'h12, 8'h34);
    in_valid = 1'b1; unit_in = 2'd0; func_in = 2'd1; a_in = 8'h05; b_in = 8'h09;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(bus_u.in_ready), 32'd0);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    issue(2'd0, 2'd1, 8'h05, 8'h09);
    @(negedge CLK);
    chk("drain_accept_valid", 32'(bus_u.out_valid), 32'd1);
    @(posedge CLK);
    #1;

    // Multiply latency and in_ready during MUL
    issue(2'd3, 2'd0, 8'h0F, 8'h11);
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge CLK);
      if (bus_u.out_valid) lat = k;
      else chk("mul_in_ready", 32'(bus_u.in_ready), 32'd0);
    end
    chk("mul_latency", 32'(lat), 32'(W + 1));
    @(posedge CLK);
    #1;
    issue(2'd3, 2'd1, 8'h10, 8'h10);
    issue(2'd3, 2'd3, 8'hFF, 8'hFF);
    idle(12);

    // Reset mid-multiply: result abandoned
    issue(2'd3, 2'd0, 8'hC3, 8'h5A);
    idle(3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(bus_u.out_valid), 32'd0);
    chk("midrst_F", 32'(bus_u.F), 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    chk("midrst_in_ready", 32'(bus_u.in_ready), 32'd1);
    idle(14);
    chk("midrst_no_stale", 32'(bus_u.out_valid), 32'd0);

    // Randomized ops with random back-pressure
    pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'h80; pick[3] = 8'h7F; pick[4] = 8'h01;
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      idle($urandom_range(0, 2));
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ra, rb);
    end
    @(posedge CLK);
    #3;
    rand_bp = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
